// File: rtl/alu_pipelined.sv
// Two-stage pipelined ALU with valid/ready handshaking on both sides.
// Stage 1 captures operands and opcode; stage 2 holds the result, and the flags commit when that result is accepted.
module alu_pipelined #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int NLANE = WIDTH / LANE;
    localparam int NBYTE = WIDTH / 8;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_RED    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [3:0]       s1_op_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cand_z_reg;
    logic             cand_v_reg;
    logic             cand_n_reg;
    logic             upd_zvn_reg;
    logic             upd_z_reg;
    logic [2:0]       flags_reg;

    logic s2_ready;
    logic s1_advance;

    assign s2_ready   = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_ready;
    assign in_ready   = !s1_valid_reg || s1_advance;

    assign out_valid = s2_valid_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;

    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] add_sat;
    logic [WIDTH-1:0] sub_sat;
    logic [WIDTH-1:0] red_sum;
    logic [WIDTH-1:0] padd_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_upd_zvn;
    logic             alu_upd_z;

    assign sh      = s1_b_reg[SHW-1:0];
    assign add_ext = {s1_a_reg[WIDTH-1], s1_a_reg} + {s1_b_reg[WIDTH-1], s1_b_reg};
    assign sub_ext = {s1_a_reg[WIDTH-1], s1_a_reg} - {s1_b_reg[WIDTH-1], s1_b_reg};
    // Overflow when the extra sign bit disagrees with the result MSB; clamp toward the true sign.
    assign add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
    assign sub_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
    assign add_sat = add_ovf ? {add_ext[WIDTH], {(WIDTH-1){~add_ext[WIDTH]}}} : add_ext[WIDTH-1:0];
    assign sub_sat = sub_ovf ? {sub_ext[WIDTH], {(WIDTH-1){~sub_ext[WIDTH]}}} : sub_ext[WIDTH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_lane
            logic [LANE-1:0] lane_a;
            logic [LANE-1:0] lane_b;
            logic [LANE:0]   lane_sum;
            assign lane_a   = s1_a_reg[gi*LANE +: LANE];
            assign lane_b   = s1_b_reg[gi*LANE +: LANE];
            assign lane_sum = {lane_a[LANE-1], lane_a} + {lane_b[LANE-1], lane_b};
            assign padd_res[gi*LANE +: LANE] = (lane_sum[LANE] ^ lane_sum[LANE-1])
                ? {lane_sum[LANE], {(LANE-1){~lane_sum[LANE]}}}
                : lane_sum[LANE-1:0];
        end
    endgenerate

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < NBYTE; i++) begin
            red_sum = red_sum + WIDTH'($signed(s1_a_reg[8*i +: 8]))
                              + WIDTH'($signed(s1_b_reg[8*i +: 8]));
        end
    end

    always_comb begin
        alu_res     = s1_a_reg + s1_b_reg;
        alu_v       = 1'b0;
        alu_upd_zvn = 1'b0;
        alu_upd_z   = 1'b0;
        case (s1_op_reg)
            OP_ADD: begin
                alu_res     = add_sat;
                alu_v       = add_ovf;
                alu_upd_zvn = 1'b1;
            end
            OP_SUB: begin
                alu_res     = sub_sat;
                alu_v       = sub_ovf;
                alu_upd_zvn = 1'b1;
            end
            OP_RED:    alu_res = red_sum;
            OP_XOR: begin
                alu_res   = s1_a_reg ^ s1_b_reg;
                alu_upd_z = 1'b1;
            end
            OP_SLL: begin
                alu_res   = s1_a_reg << sh;
                alu_upd_z = 1'b1;
            end
            OP_SRA: begin
                alu_res   = $signed(s1_a_reg) >>> sh;
                alu_upd_z = 1'b1;
            end
            OP_ROR: begin
                alu_res   = (s1_a_reg >> sh) | (s1_a_reg << (WIDTH - int'(sh)));
                alu_upd_z = 1'b1;
            end
            OP_PADDSB: alu_res = padd_res;
            default:   alu_res = s1_a_reg + s1_b_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg  <= a;
                s1_b_reg  <= b;
                s1_op_reg <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            result_reg   <= '0;
            cand_z_reg   <= 1'b0;
            cand_v_reg   <= 1'b0;
            cand_n_reg   <= 1'b0;
            upd_zvn_reg  <= 1'b0;
            upd_z_reg    <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                result_reg  <= alu_res;
                cand_z_reg  <= (alu_res == '0);
                cand_v_reg  <= alu_v;
                cand_n_reg  <= alu_res[WIDTH-1];
                upd_zvn_reg <= alu_upd_zvn;
                upd_z_reg   <= alu_upd_z;
            end
        end
    end

    // Flags are architectural: they commit only when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 3'b000;
        end else if (s2_valid_reg && out_ready) begin
            if (upd_zvn_reg) begin
                flags_reg <= {cand_z_reg, cand_v_reg, cand_n_reg};
            end else if (upd_z_reg) begin
                flags_reg[2] <= cand_z_reg;
            end
        end
    end
endmodule
